// File: rtl/serial_transceiver_pkg.sv
// -----------------------------------------------------------------------------
// serial_transceiver_pkg
// Shared definitions for the UART echo transceiver:
//   - uart_state_t : state encoding used by both the receive and transmit FSMs
//   - period_t     : width of a cycles-per-bit value / bit-timer count
//   - BIT_*        : the four selectable cycles-per-bit values (100 MHz clock)
//   - FRAME_W      : number of data bits in a frame
//   - bit_period() : maps the 2-bit baud select onto a cycles-per-bit value
// -----------------------------------------------------------------------------
package serial_transceiver_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   localparam int unsigned CNT_W   = 14;
   localparam int unsigned FRAME_W = 8;

   typedef logic [CNT_W-1:0] period_t;

   localparam period_t BIT_9600   = 14'd10416;
   localparam period_t BIT_19200  = 14'd5208;
   localparam period_t BIT_38400  = 14'd2604;
   localparam period_t BIT_115200 = 14'd868;

   // Cycles-per-bit for a given baud select code.
   function automatic period_t bit_period(input logic [1:0] sel);
      period_t p;
      case (sel)
         2'b00:   p = BIT_9600;
         2'b01:   p = BIT_19200;
         2'b10:   p = BIT_38400;
         2'b11:   p = BIT_115200;
         default: p = BIT_9600;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/serial_transceiver_uart_bit_timer.sv
// -----------------------------------------------------------------------------
// uart_bit_timer
// Loadable down-counter that produces a one-cycle terminal-count strobe.
// Loading value N makes tc fire exactly N cycles after the load cycle, so
// reloading on every tc gives a strobe with a period of exactly N cycles.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   load       : load the counter with value (takes priority over clr)
//   value      : count to load
//   clr        : stop the counter (no further tc until the next load)
//   tc         : terminal-count strobe
// -----------------------------------------------------------------------------
module uart_bit_timer
   import serial_transceiver_pkg::*;
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    load,
   input  period_t value,
   input  logic    clr,
   output logic    tc
);

   period_t count_r;

   // Down-counter: load, clear, or count towards zero and park there.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_r <= 14'd0;
      end else if (load) begin
         count_r <= value;
      end else if (clr) begin
         count_r <= 14'd0;
      end else if (count_r != 14'd0) begin
         count_r <= count_r - 14'd1;
      end else begin
         count_r <= count_r;
      end
   end

   // The strobe is the last counting cycle, decoded straight from the register.
   assign tc = (count_r == 14'd1);

endmodule

// File: rtl/serial_transceiver.sv
// -----------------------------------------------------------------------------
// serial_transceiver
// UART receiver plus echoing transmitter (8N1, LSB first). Every correctly
// framed byte is presented on rx_data with a one-cycle rx_valid strobe and,
// if the transmitter is idle, is sent back out on dout.
// Ports:
//   dout     : serial output, idle high (echo of received bytes)
//   rx_data  : last correctly framed received byte
//   rx_valid : one-cycle strobe when rx_data updates
//   tx_busy  : high while a frame is being transmitted
//   din      : asynchronous serial input, idle high
//   baud_sel : cycles-per-bit select (00=10416, 01=5208, 10=2604, 11=868)
//   clk      : system clock
//   rst_n    : asynchronous active-low reset
// -----------------------------------------------------------------------------
module serial_transceiver
   import serial_transceiver_pkg::*;
(
   output logic               dout,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   output logic               tx_busy,
   input  logic               din,
   input  logic [1:0]         baud_sel,
   input  logic               clk,
   input  logic               rst_n
);

   // ---------------- input synchronizer / edge detect ----------------
   logic sync1_r;
   logic sync2_r;
   logic din_prev_r;
   logic fall_s;

   // ---------------- receiver ----------------
   uart_state_t        rx_state_r;
   uart_state_t        rx_state_s;
   period_t            rx_bit_r;
   logic [FRAME_W-1:0] rx_shift_r;
   logic [FRAME_W-1:0] rx_data_r;
   logic [3:0]         rx_cnt_r;
   logic               rx_valid_r;
   logic               rx_load_s;
   logic               rx_clr_s;
   period_t            rx_val_s;
   logic               rx_tc_s;

   // ---------------- transmitter ----------------
   uart_state_t        tx_state_r;
   uart_state_t        tx_state_s;
   period_t            tx_bit_r;
   logic [FRAME_W-1:0] tx_shift_r;
   logic [3:0]         tx_cnt_r;
   logic               dout_r;
   logic               tx_busy_r;
   logic               tx_load_s;
   logic               tx_clr_s;
   period_t            tx_val_s;
   logic               tx_tc_s;

   // Two-flop synchronizer plus one history flop for falling-edge detection.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r    <= 1'b1;
         sync2_r    <= 1'b1;
         din_prev_r <= 1'b1;
      end else begin
         sync1_r    <= din;
         sync2_r    <= sync1_r;
         din_prev_r <= sync2_r;
      end
   end

   // A start edge needs the line to have been high first, so after a framing
   // error (line still low) the receiver only re-arms once din returns to 1.
   assign fall_s = din_prev_r & ~sync2_r;

   uart_bit_timer u_rx_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (rx_load_s),
      .value (rx_val_s),
      .clr   (rx_clr_s),
      .tc    (rx_tc_s)
   );

   uart_bit_timer u_tx_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (tx_load_s),
      .value (tx_val_s),
      .clr   (tx_clr_s),
      .tc    (tx_tc_s)
   );

   // Receiver state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_state_r <= ST_IDLE;
      end else begin
         rx_state_r <= rx_state_s;
      end
   end

   // Receiver next state and bit-timer control. The first wait is half a
   // bit so that every later sample lands mid-bit.
   always_comb begin
      rx_state_s = rx_state_r;
      rx_load_s  = 1'b0;
      rx_val_s   = rx_bit_r;
      rx_clr_s   = 1'b0;
      case (rx_state_r)
         ST_IDLE: begin
            if (fall_s) begin
               rx_state_s = ST_START;
               rx_load_s  = 1'b1;
               rx_val_s   = bit_period(baud_sel) >> 1;
            end else begin
               rx_state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (rx_tc_s) begin
               if (!sync2_r) begin
                  rx_state_s = ST_DATA;
                  rx_load_s  = 1'b1;
               end else begin
                  // line went back high: treat the low pulse as a glitch
                  rx_state_s = ST_IDLE;
                  rx_clr_s   = 1'b1;
               end
            end else begin
               rx_state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (rx_tc_s) begin
               rx_load_s = 1'b1;
               if (rx_cnt_r == 4'd7) begin
                  rx_state_s = ST_STOP;
               end else begin
                  rx_state_s = ST_DATA;
               end
            end else begin
               rx_state_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (rx_tc_s) begin
               rx_state_s = ST_IDLE;
               rx_clr_s   = 1'b1;
            end else begin
               rx_state_s = ST_STOP;
            end
         end
         default: begin
            rx_state_s = ST_IDLE;
            rx_clr_s   = 1'b1;
         end
      endcase
   end

   // Receiver datapath: bit period capture, shift register and byte output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_bit_r   <= 14'd0;
         rx_shift_r <= 8'h00;
         rx_data_r  <= 8'h00;
         rx_cnt_r   <= 4'd0;
         rx_valid_r <= 1'b0;
      end else begin
         rx_valid_r <= 1'b0;
         case (rx_state_r)
            ST_IDLE: begin
               // baud_sel only matters between frames
               rx_bit_r <= bit_period(baud_sel);
               rx_cnt_r <= 4'd0;
            end
            ST_DATA: begin
               if (rx_tc_s) begin
                  rx_shift_r <= {sync2_r, rx_shift_r[FRAME_W-1:1]};
                  rx_cnt_r   <= rx_cnt_r + 4'd1;
               end else begin
                  rx_shift_r <= rx_shift_r;
               end
            end
            ST_STOP: begin
               // a low stop bit drops the byte and keeps the previous rx_data
               if (rx_tc_s && sync2_r) begin
                  rx_data_r  <= rx_shift_r;
                  rx_valid_r <= 1'b1;
               end else begin
                  rx_data_r  <= rx_data_r;
               end
            end
            default: begin
               rx_cnt_r <= rx_cnt_r;
            end
         endcase
      end
   end

   // Transmitter state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_state_r <= ST_IDLE;
      end else begin
         tx_state_r <= tx_state_s;
      end
   end

   // Transmitter next state and bit-timer control; a byte that arrives while
   // a frame is in flight is simply not accepted.
   always_comb begin
      tx_state_s = tx_state_r;
      tx_load_s  = 1'b0;
      tx_val_s   = tx_bit_r;
      tx_clr_s   = 1'b0;
      case (tx_state_r)
         ST_IDLE: begin
            if (rx_valid_r) begin
               tx_state_s = ST_START;
               tx_load_s  = 1'b1;
               tx_val_s   = bit_period(baud_sel);
            end else begin
               tx_state_s = ST_IDLE;
            end
         end
         ST_START: begin
            if (tx_tc_s) begin
               tx_state_s = ST_DATA;
               tx_load_s  = 1'b1;
            end else begin
               tx_state_s = ST_START;
            end
         end
         ST_DATA: begin
            if (tx_tc_s) begin
               tx_load_s = 1'b1;
               if (tx_cnt_r == 4'd8) begin
                  tx_state_s = ST_STOP;
               end else begin
                  tx_state_s = ST_DATA;
               end
            end else begin
               tx_state_s = ST_DATA;
            end
         end
         ST_STOP: begin
            if (tx_tc_s) begin
               tx_state_s = ST_IDLE;
               tx_clr_s   = 1'b1;
            end else begin
               tx_state_s = ST_STOP;
            end
         end
         default: begin
            tx_state_s = ST_IDLE;
            tx_clr_s   = 1'b1;
         end
      endcase
   end

   // Transmitter datapath. tx_cnt_r counts data bits already driven onto
   // dout; once all 8 have had their full bit time the stop bit goes out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_bit_r   <= 14'd0;
         tx_shift_r <= 8'h00;
         tx_cnt_r   <= 4'd0;
         dout_r     <= 1'b1;
         tx_busy_r  <= 1'b0;
      end else begin
         case (tx_state_r)
            ST_IDLE: begin
               tx_bit_r <= bit_period(baud_sel);
               if (rx_valid_r) begin
                  tx_shift_r <= rx_data_r;
                  tx_cnt_r   <= 4'd0;
                  dout_r     <= 1'b0;
                  tx_busy_r  <= 1'b1;
               end else begin
                  dout_r     <= 1'b1;
                  tx_busy_r  <= 1'b0;
               end
            end
            ST_START: begin
               if (tx_tc_s) begin
                  dout_r     <= tx_shift_r[0];
                  tx_shift_r <= {1'b0, tx_shift_r[FRAME_W-1:1]};
                  tx_cnt_r   <= 4'd1;
               end else begin
                  dout_r     <= dout_r;
               end
            end
            ST_DATA: begin
               if (tx_tc_s) begin
                  if (tx_cnt_r == 4'd8) begin
                     dout_r <= 1'b1;
                  end else begin
                     dout_r     <= tx_shift_r[0];
                     tx_shift_r <= {1'b0, tx_shift_r[FRAME_W-1:1]};
                     tx_cnt_r   <= tx_cnt_r + 4'd1;
                  end
               end else begin
                  dout_r <= dout_r;
               end
            end
            ST_STOP: begin
               if (tx_tc_s) begin
                  dout_r    <= 1'b1;
                  tx_busy_r <= 1'b0;
               end else begin
                  dout_r    <= dout_r;
               end
            end
            default: begin
               dout_r    <= 1'b1;
               tx_busy_r <= 1'b0;
            end
         endcase
      end
   end

   assign dout     = dout_r;
   assign rx_data  = rx_data_r;
   assign rx_valid = rx_valid_r;
   assign tx_busy  = tx_busy_r;

endmodule

// File: tb/tb_serial_transceiver.sv
// -----------------------------------------------------------------------------
// tb_serial_transceiver
// Drives UART frames into din at 868 clk/bit from a table of records and
// checks reception and the echo on dout against expectations built from the
// frame rules (start 0, 8 data LSB first, stop 1; echo starts the cycle after
// rx_valid, each bit BIT cycles, tx_busy drops the cycle after the stop bit).
// -----------------------------------------------------------------------------
module tb_serial_transceiver;

   localparam int BIT = 868;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       din = 1'b1;
   logic [1:0] baud_sel = 2'b11;
   logic       dout;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       tx_busy;

   serial_transceiver dut (
      .dout     (dout),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_busy  (tx_busy),
      .din      (din),
      .baud_sel (baud_sel),
      .clk      (clk),
      .rst_n    (rst_n)
   );

   always #5 clk = ~clk;

   // kind: 0 good frame, 1 short glitch, 2 bad stop bit, 3 good frame + reset mid-echo
   typedef struct {
      int         kind;
      logic [9:0] bits;   // bits[k] is the k-th bit on the line
      logic [7:0] data;
      bit         wiggle; // toggle baud_sel mid-frame
   } vec_t;

   typedef struct {
      logic [9:0] bits;
      logic [7:0] data;
      int         nbits;
   } exp_t;

   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];
   bit   chk_busy = 1'b0;
   int   valid_cnt = 0;
   int   tx_start_cnt = 0;
   logic busy_prev = 1'b0;
   int   exp_valid = 0;
   int   exp_echo = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [9:0] frame_of(input logic [7:0] d);
      return {1'b1, d, 1'b0};
   endfunction

   always @(posedge clk) begin
      if (rx_valid === 1'b1) valid_cnt <= valid_cnt + 1;
      if (tx_busy === 1'b1 && busy_prev === 1'b0) tx_start_cnt <= tx_start_cnt + 1;
      busy_prev <= tx_busy;
   end

   task automatic send_frame(input logic [9:0] bits, input bit wiggle);
      for (int k = 0; k < 10; k++) begin
         din = bits[k];
         if (wiggle && k == 2) baud_sel = 2'b00;
         if (wiggle && k == 7) baud_sel = 2'b11;
         repeat (BIT) @(posedge clk);
         #1;
      end
   endtask

   // Echo checker: consumes expected bytes in order.
   initial begin
      exp_t e;
      int   t;
      int   pos;
      int   target;
      forever begin
         @(posedge clk);
         if (exp_q.size() != 0) begin
            e = exp_q[0];
            chk_busy = 1'b1;
            t = 0;
            #1;
            while (rx_valid !== 1'b1 && t < 12 * BIT) begin
               @(posedge clk);
               #1;
               t++;
            end
            if (rx_valid !== 1'b1) begin
               check("rx_valid_timeout", 32'd0, 32'd1);
            end else begin
               check("rx_data", 32'(rx_data), 32'(e.data));
               @(posedge clk);
               #1;
               check("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
               check("echo_start_dout", 32'(dout), 32'd0);
               check("echo_start_busy", 32'(tx_busy), 32'd1);
               pos = 1;
               for (int k = 0; k < e.nbits; k++) begin
                  target = 1 + k * BIT + BIT / 2;
                  repeat (target - pos) @(posedge clk);
                  #1;
                  pos = target;
                  check("echo_bit", 32'(dout), 32'(e.bits[k]));
                  check("echo_busy", 32'(tx_busy), 32'd1);
               end
               if (e.nbits == 10) begin
                  repeat (10 * BIT - pos) @(posedge clk);
                  #1;
                  check("stop_last_cycle_busy", 32'(tx_busy), 32'd1);
                  check("stop_last_cycle_dout", 32'(dout), 32'd1);
                  @(posedge clk);
                  #1;
                  check("busy_fall", 32'(tx_busy), 32'd0);
               end
            end
            void'(exp_q.pop_front());
            chk_busy = 1'b0;
         end
      end
   end

   // Stimulus driver.
   initial begin
      vec_t       tbl[7];
      logic [7:0] r1;
      logic [7:0] r3;
      int         t;
      exp_t       e;

      r1 = 8'($urandom);
      r3 = 8'($urandom);
      tbl[0] = '{kind: 0, bits: 10'b1011000110, data: 8'h63, wiggle: 1'b0};
      tbl[1] = '{kind: 0, bits: 10'b1100011100, data: 8'h8E, wiggle: 1'b1};
      tbl[2] = '{kind: 1, bits: 10'h3FF,        data: 8'h00, wiggle: 1'b0};
      tbl[3] = '{kind: 2, bits: {1'b0, 8'h55, 1'b0}, data: 8'h55, wiggle: 1'b0};
      tbl[4] = '{kind: 0, bits: frame_of(r1),   data: r1,    wiggle: 1'b0};
      tbl[5] = '{kind: 3, bits: frame_of(8'hC3), data: 8'hC3, wiggle: 1'b0};
      tbl[6] = '{kind: 0, bits: frame_of(r3),   data: r3,    wiggle: 1'b0};

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("reset_dout", 32'(dout), 32'd1);
      check("reset_tx_busy", 32'(tx_busy), 32'd0);
      check("reset_rx_valid", 32'(rx_valid), 32'd0);
      check("reset_rx_data", 32'(rx_data), 32'h00);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("idle_dout", 32'(dout), 32'd1);
      check("idle_rx_valid", 32'(rx_valid), 32'd0);

      for (int i = 0; i < 7; i++) begin
         case (tbl[i].kind)
            0, 3: begin
               e.bits  = tbl[i].bits;
               e.data  = tbl[i].data;
               e.nbits = (tbl[i].kind == 3) ? 2 : 10;
               exp_q.push_back(e);
               exp_valid++;
               exp_echo++;
               send_frame(tbl[i].bits, tbl[i].wiggle);
               if (tbl[i].kind == 3) begin
                  t = 0;
                  while (valid_cnt < exp_valid && t < 4 * BIT) begin
                     @(posedge clk);
                     #1;
                     t++;
                  end
                  check("reset_frame_rx", 32'(valid_cnt), 32'(exp_valid));
                  repeat (3 * BIT) @(posedge clk);
                  #1;
                  check("pre_reset_dout", 32'(dout), 32'(tbl[i].bits[3]));
                  check("pre_reset_busy", 32'(tx_busy), 32'd1);
                  #2;
                  rst_n = 1'b0;
                  #1;
                  check("midecho_reset_dout", 32'(dout), 32'd1);
                  check("midecho_reset_busy", 32'(tx_busy), 32'd0);
                  check("midecho_reset_valid", 32'(rx_valid), 32'd0);
                  check("midecho_reset_rx_data", 32'(rx_data), 32'h00);
                  repeat (3) @(posedge clk);
                  #1;
                  rst_n = 1'b1;
               end
            end
            1: begin
               din = 1'b0;
               repeat (BIT / 4) @(posedge clk);
               #1;
               din = 1'b1;
               repeat (BIT) @(posedge clk);
               #1;
            end
            2: begin
               send_frame(tbl[i].bits, tbl[i].wiggle);
            end
            default: begin
               din = 1'b1;
            end
         endcase
         din = 1'b1;
         repeat (BIT / 2) @(posedge clk);
         #1;
         check("valid_count", 32'(valid_cnt), 32'(exp_valid));
      end

      t = 0;
      while ((exp_q.size() != 0 || chk_busy) && t < 15 * BIT) begin
         @(posedge clk);
         #1;
         t++;
      end
      check("drain", 32'(exp_q.size()), 32'd0);
      check("total_rx_valid", 32'(valid_cnt), 32'(exp_valid));
      check("total_echo_frames", 32'(tx_start_cnt), 32'(exp_echo));
      check("final_dout", 32'(dout), 32'd1);
      check("final_tx_busy", 32'(tx_busy), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/serial_transceiver.md
SERIAL_TRANSCEIVER -- requirements
Module: serial_transceiver

Interface
- REQ-001: The block SHALL use one clock and an asynchronous, active-low reset; the ports are named clk and rst_n.
- REQ-002: Positional port order SHALL be dout, rx_data, rx_valid, tx_busy, din, baud_sel, clk, rst_n.
- REQ-003: clk  input  1  system clock, 100 MHz nominal.
- REQ-004: rst_n  input  1  asynchronous active-low reset.
- REQ-005: din  input  1  asynchronous UART serial input, idle high.
- REQ-006: baud_sel  input  2  bit-period select: 00 = 10416 clk/bit (9600 baud), 01 = 5208, 10 = 2604, 11 = 868 (115200 baud).
- REQ-007: dout  output  1  UART serial output, idle high; echoes each received byte.
- REQ-008: rx_data  output  8  last correctly framed received byte.
- REQ-009: rx_valid  output  1  one-cycle strobe when rx_data updates.
- REQ-010: tx_busy  output  1  high while the transmitter is sending a frame.

Function
- REQ-011: Frame format SHALL be 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity.
- REQ-012: din SHALL pass through a 2-flop synchronizer before any use.
- REQ-013: Receiver FSM states SHALL be IDLE, START, DATA, STOP.
- REQ-014: IDLE->START occurs on a synchronized 1->0 transition of din.
- REQ-015: In START, the receiver SHALL wait BIT/2 cycles; if din is 0 it goes to DATA, otherwise it returns to IDLE (glitch rejection).
- REQ-016: In DATA, the receiver SHALL sample once every BIT cycles, shifting in LSB first; after 8 samples it goes to STOP.
- REQ-017: In STOP, the receiver SHALL sample after BIT cycles; if 1, it loads rx_data, pulses rx_valid for 1 cycle and returns to IDLE.
- REQ-018: If the stop sample is 0 (framing error), the receiver SHALL discard the byte, keep rx_data, not pulse rx_valid, and wait in IDLE for din=1 before re-arming.
- REQ-019: BIT SHALL be the cycles-per-bit value from baud_sel; baud_sel is sampled only in IDLE, and a change mid-frame takes effect at the next frame.
- REQ-020: Transmitter FSM states SHALL be IDLE, START, DATA, STOP, each bit held exactly BIT cycles.
- REQ-021: On rx_valid with the transmitter idle, the transmitter SHALL start on the next cycle with dout=0 and tx_busy=1, send rx_data LSB first, then the stop bit, then return to idle.
- REQ-022: A received byte arriving while tx_busy=1 SHALL be dropped by the transmitter (rx_data/rx_valid are still updated).
- REQ-023: tx_busy SHALL fall in the cycle after the stop bit's BIT cycles complete.
- REQ-024: Receiver and transmitter SHALL run concurrently; at equal baud, back-to-back frames never overlap a busy transmitter.

Reset
- REQ-025: When rst_n=0, the block SHALL immediately force both FSMs to IDLE, all counters to 0, dout=1, rx_data=8'h00, rx_valid=0, tx_busy=0, and the synchronizer flops to 1.
- REQ-026: Reset asserted mid-frame SHALL abort both frames; after release, the receiver waits for a fresh falling edge.

Structure
- REQ-027: A shared package SHALL hold the FSM state typedef, the four cycles-per-bit constants, and the frame width (8).
- REQ-028: The block SHALL contain one sub-module, uart_bit_timer (loadable down-counter with terminal-count strobe), instantiated once each for RX and TX.

Verification
- REQ-029: Reset, din held 1 -> dout=1, tx_busy=0, rx_valid=0, rx_data=00.
- REQ-030: baud_sel=00, din frame 0,1,1,0,0,0,1,1,0,1 at 10416 clk/bit -> rx_valid pulse, rx_data=8'h63, then dout emits 0,1,1,0,0,0,1,1,0,1 at 10416 clk/bit with tx_busy high for 10 bits.
- REQ-031: Idle gap, then frame 0,0,1,1,1,0,0,0,1,1 -> rx_data=8'h8E; dout echoes the same 10 bits.
- REQ-032: din low pulse shorter than BIT/2 -> no rx_valid, dout stays 1.
- REQ-033: Frame with stop bit 0 -> no rx_valid, no echo; the next valid frame is received correctly.
- REQ-034: rst_n pulsed low mid-echo -> dout=1 and tx_busy=0 immediately; the next frame is received and echoed normally.
